// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: turns direction/step-count/edge-period commands
// into Gray-code CHN_A/CHN_B transitions and tracks the emulated shaft position.
module quad_encoder_emulator #(
  parameter int CNT_PER_REV = 1200,
  parameter int STEPS_W     = 16,
  parameter int DIV_W       = 16,
  localparam int POS_W      = $clog2(CNT_PER_REV)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic               CMD_DIR,
  input  logic [STEPS_W-1:0] CMD_STEPS,
  input  logic [DIV_W-1:0]   CMD_DIV,
  input  logic               ABORT,
  output logic               CHN_A,
  output logic               CHN_B,
  output logic               INDEX,
  output logic [POS_W-1:0]   POSITION,
  output logic               BUSY,
  output logic               DONE
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [POS_W-1:0]   POS_ZERO   = {POS_W{1'b0}};
  localparam logic [POS_W-1:0]   POS_ONE    = POS_W'(1);
  localparam logic [POS_W-1:0]   POS_MAX    = POS_W'(CNT_PER_REV - 1);
  localparam logic [DIV_W-1:0]   DIV_ZERO   = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0]   DIV_ONE    = DIV_W'(1);
  localparam logic [STEPS_W-1:0] STEPS_ZERO = {STEPS_W{1'b0}};
  localparam logic [STEPS_W-1:0] STEPS_ONE  = STEPS_W'(1);

  // {B,A} Gray sequence: CW 00->10->11->01, CCW the reverse.
  function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic dir);
    logic [1:0] res;
    case (ph)
      2'b00:   res = dir ? 2'b01 : 2'b10;
      2'b10:   res = dir ? 2'b00 : 2'b11;
      2'b11:   res = dir ? 2'b10 : 2'b01;
      2'b01:   res = dir ? 2'b11 : 2'b00;
      default: res = 2'b00;
    endcase
    return res;
  endfunction

  function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] pos, input logic dir);
    logic [POS_W-1:0] res;
    if (dir) begin
      res = (pos == POS_ZERO) ? POS_MAX : pos - POS_ONE;
    end else begin
      res = (pos == POS_MAX) ? POS_ZERO : pos + POS_ONE;
    end
    return res;
  endfunction

  state_t             state_r, state_s;
  logic               dir_r, dir_s;
  logic [STEPS_W-1:0] rem_r, rem_s;
  logic [DIV_W-1:0]   div_r, div_s;
  logic [DIV_W-1:0]   cnt_r, cnt_s;
  logic [1:0]         phase_r, phase_s;
  logic [POS_W-1:0]   pos_r, pos_s;
  logic               index_r, index_s;
  logic               done_r, done_s;
  logic               ready_r, ready_s;
  logic               busy_r, busy_s;
  logic               at_edge_s;
  logic [1:0]         phase_adv_s;
  logic [POS_W-1:0]   pos_adv_s;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_s     = state_r;
    dir_s       = dir_r;
    rem_s       = rem_r;
    div_s       = div_r;
    cnt_s       = cnt_r;
    phase_s     = phase_r;
    pos_s       = pos_r;
    done_s      = 1'b0;
    at_edge_s   = (cnt_r == (div_r - DIV_ONE));
    phase_adv_s = next_phase(phase_r, dir_r);
    pos_adv_s   = next_pos(pos_r, dir_r);

    case (state_r)
      ST_IDLE: begin
        if (CMD_VALID && ready_r) begin
          dir_s = CMD_DIR;
          rem_s = CMD_STEPS;
          div_s = (CMD_DIV == DIV_ZERO) ? DIV_ONE : CMD_DIV;
          cnt_s = DIV_ZERO;
          if (CMD_STEPS == STEPS_ZERO) begin
            done_s = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // A final edge wins over ABORT; any other edge is suppressed by it.
        if (at_edge_s && (rem_r == STEPS_ONE)) begin
          phase_s = phase_adv_s;
          pos_s   = pos_adv_s;
          rem_s   = STEPS_ZERO;
          cnt_s   = DIV_ZERO;
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else if (ABORT) begin
          rem_s   = STEPS_ZERO;
          cnt_s   = DIV_ZERO;
          state_s = ST_IDLE;
        end else if (at_edge_s) begin
          phase_s = phase_adv_s;
          pos_s   = pos_adv_s;
          rem_s   = rem_r - STEPS_ONE;
          cnt_s   = DIV_ZERO;
        end else begin
          cnt_s = cnt_r + DIV_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    index_s = (pos_s == POS_ZERO);
    ready_s = (state_s == ST_IDLE);
    busy_s  = (state_s == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      dir_r   <= 1'b0;
      rem_r   <= STEPS_ZERO;
      div_r   <= DIV_ONE;
      cnt_r   <= DIV_ZERO;
      phase_r <= 2'b00;
      pos_r   <= POS_ZERO;
      index_r <= 1'b1;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      dir_r   <= dir_s;
      rem_r   <= rem_s;
      div_r   <= div_s;
      cnt_r   <= cnt_s;
      phase_r <= phase_s;
      pos_r   <= pos_s;
      index_r <= index_s;
      done_r  <= done_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
    end
  end

  assign CHN_A     = phase_r[0];
  assign CHN_B     = phase_r[1];
  assign POSITION  = pos_r;
  assign INDEX     = index_r;
  assign DONE      = done_r;
  assign CMD_READY = ready_r;
  assign BUSY      = busy_r;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Bench for quad_encoder_emulator: command table plus an edge scoreboard that
// predicts every phase change / DONE pulse with its cycle number.
module tb_quad_encoder_emulator;

  localparam int CPR   = 1200;
  localparam int POS_W = $clog2(CPR);

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             CMD_VALID = 1'b0;
  logic             CMD_DIR = 1'b0;
  logic [15:0]      CMD_STEPS = 16'd0;
  logic [15:0]      CMD_DIV = 16'd0;
  logic             ABORT = 1'b0;
  logic             CMD_READY, CHN_A, CHN_B, INDEX, BUSY, DONE;
  logic [POS_W-1:0] POSITION;

  quad_encoder_emulator dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_DIR(CMD_DIR), .CMD_STEPS(CMD_STEPS), .CMD_DIV(CMD_DIV), .ABORT(ABORT),
    .CHN_A(CHN_A), .CHN_B(CHN_B), .INDEX(INDEX), .POSITION(POSITION),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [1:0] ba;
    int         pos;
    logic       done;
  } ev_t;

  // mode: 0 plain, 1 ABORT during accept, 2 ABORT after n_edges, 3 ABORT on final edge
  typedef struct {
    logic       dir;
    int         steps;
    int         div;
    int         n_edges;
    int         mode;
    logic [1:0] exp_ba;
    int         exp_pos;
  } vec_t;

  ev_t        sb[$];
  vec_t       vecs[12];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [1:0] cw_seq[4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int         m_q = 0;
  int         m_pos = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one command, pushing the predicted events for the first n_push edges.
  task automatic issue(input logic dir, input int steps, input int div, input int n_push,
                       input logic abort_acc, output int t);
    int w;
    int d;
    w = 0;
    @(negedge CLK);
    while (!CMD_READY && w < 200) begin
      @(negedge CLK);
      w++;
    end
    check("ready_before_cmd", CMD_READY, 1);
    t = cyc + 1;
    d = (div == 0) ? 1 : div;
    CMD_VALID = 1'b1;
    CMD_DIR   = dir;
    CMD_STEPS = 16'(steps);
    CMD_DIV   = 16'(div);
    ABORT     = abort_acc;
    if (steps == 0) begin
      sb.push_back('{t, cw_seq[m_q], m_pos, 1'b1});
    end else begin
      for (int k = 1; k <= n_push; k++) begin
        m_q   = dir ? (m_q + 3) % 4 : (m_q + 1) % 4;
        m_pos = dir ? (m_pos + CPR - 1) % CPR : (m_pos + 1) % CPR;
        sb.push_back('{t + k * d, cw_seq[m_q], m_pos, (k == steps)});
      end
    end
    @(negedge CLK);
    CMD_VALID = 1'b0;
    ABORT     = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int t;
    int d;
    int abort_cyc;
    int w;
    issue(v.dir, v.steps, v.div, v.n_edges, (v.mode == 1), t);
    d = (v.div == 0) ? 1 : v.div;
    if (v.mode >= 2) begin
      abort_cyc = t + v.n_edges * d - ((v.mode == 3) ? 1 : 0);
      w = 0;
      while (cyc < abort_cyc && w < 5000) begin
        @(negedge CLK);
        w++;
      end
      ABORT = 1'b1;
      @(negedge CLK);
      ABORT = 1'b0;
      check("abort_busy_low", BUSY, 0);
      check("abort_ready_high", CMD_READY, 1);
    end
    w = 0;
    while (!(sb.size() == 0 && CMD_READY) && w < v.steps * d + 50) begin
      @(negedge CLK);
      w++;
    end
    check("scoreboard_drained", sb.size(), 0);
    @(negedge CLK);
    check("final_phase", {CHN_B, CHN_A}, v.exp_ba);
    check("final_position", POSITION, v.exp_pos);
    check("final_index", INDEX, (v.exp_pos == 0));
    check("final_busy", BUSY, 0);
    check("final_done", DONE, 0);
    check("final_ready", CMD_READY, 1);
  endtask

  // Monitor: every phase change or DONE pulse must match the head of the scoreboard.
  initial begin
    logic [1:0] prev;
    logic [1:0] cur;
    ev_t        e;
    prev = 2'b00;
    forever begin
      @(negedge CLK);
      cur = {CHN_B, CHN_A};
      if (RST) begin
        prev = cur;
      end else begin
        if (cur !== prev || DONE) begin
          if (sb.size() == 0) begin
            check("stray_event_phase_done", {cur, DONE}, {prev, 1'b0});
          end else begin
            e = sb.pop_front();
            check("edge_cycle", cyc, e.t);
            check("edge_phase", cur, e.ba);
            check("edge_position", POSITION, e.pos);
            check("edge_index", INDEX, (e.pos == 0));
            check("edge_done", DONE, e.done);
            check("one_channel_change", ($countones(cur ^ prev) <= 1), 1);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    int t;
    int w;
    vecs[0]  = '{1'b0, 4,    3, 4,    0, 2'b00, 4};
    vecs[1]  = '{1'b1, 4,    2, 4,    1, 2'b00, 0};
    vecs[2]  = '{1'b1, 2,    1, 2,    0, 2'b11, 1198};
    vecs[3]  = '{1'b0, 2,    1, 2,    0, 2'b00, 0};
    vecs[4]  = '{1'b0, 1202, 1, 1202, 0, 2'b11, 2};
    vecs[5]  = '{1'b0, 0,    0, 0,    0, 2'b11, 2};
    vecs[6]  = '{1'b0, 3,    0, 3,    0, 2'b10, 5};
    vecs[7]  = '{1'b1, 3,    1, 3,    3, 2'b11, 2};
    vecs[8]  = '{1'b1, 2,    2, 2,    0, 2'b00, 0};
    vecs[9]  = '{1'b0, 10,   5, 2,    2, 2'b11, 2};
    vecs[10] = '{1'b1, 2,    3, 2,    0, 2'b00, 0};
    vecs[11] = '{1'b0, 1,    1, 1,    0, 2'b10, 1};

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("reset_phase", {CHN_B, CHN_A}, 2'b00);
    check("reset_position", POSITION, 0);
    check("reset_index", INDEX, 1);
    check("reset_ready", CMD_READY, 1);
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);

    for (int i = 0; i <= 10; i++) begin
      run_vec(vecs[i]);
    end

    // Asynchronous reset in the middle of an 8-step, div=4 command.
    issue(1'b0, 8, 4, 2, 1'b0, t);
    w = 0;
    while (cyc < t + 10 && w < 100) begin
      @(negedge CLK);
      w++;
    end
    #2 RST = 1'b1;
    #1;
    check("async_rst_phase", {CHN_B, CHN_A}, 2'b00);
    check("async_rst_position", POSITION, 0);
    check("async_rst_index", INDEX, 1);
    check("async_rst_busy", BUSY, 0);
    check("async_rst_done", DONE, 0);
    check("async_rst_ready", CMD_READY, 1);
    check("async_rst_sb_empty", sb.size(), 0);
    sb.delete();
    m_q   = 0;
    m_pos = 0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    check("post_rst_ready", CMD_READY, 1);
    check("post_rst_busy", BUSY, 0);
    check("post_rst_phase", {CHN_B, CHN_A}, 2'b00);
    check("post_rst_position", POSITION, 0);

    run_vec(vecs[11]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
